// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared widths and hazard-cause encoding for the decode-stage hazard unit
package pipe_hazard_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int LAT_W      = 3;
  localparam int NUM_REGS   = 16;
  localparam int STAT_W     = 16;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RAW_A = 2'd1,
    RAW_B = 2'd2,
    WAW   = 2'd3
  } hazard_cause_e;

endpackage

// File: rtl/scoreboard_stall_unit_if.sv
// rtl/scoreboard_stall_unit_if.sv - decoder-to-hazard-unit bundle and pipeline enable outputs
interface scoreboard_stall_unit_if #(
  parameter int STAT_W = 16
) ();
  import pipe_hazard_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic [LAT_W-1:0]      id_lat;
  logic                  ex_flush;

  logic                  stall;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  idex_bubble;
  logic [NUM_REGS-1:0]   busy_mask;
  logic [STAT_W-1:0]     stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_write, id_lat, ex_flush,
    input  stall, pc_write, ifid_write, idex_bubble, busy_mask, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_write, id_lat, ex_flush,
    output stall, pc_write, ifid_write, idex_bubble, busy_mask, stall_cycles
  );

endinterface

// File: rtl/scoreboard_stall_unit_sb_counter.sv
// rtl/scoreboard_stall_unit_sb_counter.sv - one scoreboard slot: loadable countdown to zero
module sb_counter
  import pipe_hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic [LAT_W-1:0] count_o,
  output logic             busy_o
);

  logic [LAT_W-1:0] count_q;
  logic [LAT_W-1:0] count_d;

  // A new producer overrides the in-flight countdown of the same register.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign busy_o  = (count_q != '0);

endmodule

// File: rtl/scoreboard_stall_unit.sv
// rtl/scoreboard_stall_unit.sv - decode-stage scoreboard: stalls consumers of in-flight multi-cycle results
module scoreboard_stall_unit
  import pipe_hazard_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  scoreboard_stall_unit_if.slave bus
);

  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                raw_a;
  logic                raw_b;
  logic                waw;
  logic                stall;
  logic                issue;
  hazard_cause_e       cause;
  logic [STAT_W-1:0]   stat_q;
  logic [STAT_W-1:0]   stat_d;

  // r0 is hardwired zero, so it is never tracked and never busy.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_slot
    logic load;
    assign load = issue & bus.id_reg_write & (bus.id_rd == REG_ADDR_W'(i)) & (bus.id_lat != '0);

    sb_counter u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .load_val_i (bus.id_lat),
      .count_o    (cnt[i]),
      .busy_o     (busy[i])
    );
  end

  always_comb begin
    raw_a = bus.id_uses_rs & (cnt[bus.id_rs] != '0);
    raw_b = bus.id_uses_rt & (cnt[bus.id_rt] != '0);
    // A younger write may only retire once the older one finishes no later than it.
    waw   = bus.id_reg_write & (bus.id_rd != '0) & (cnt[bus.id_rd] > bus.id_lat);
    stall = bus.id_valid & ~bus.ex_flush & (raw_a | raw_b | waw);
    issue = bus.id_valid & ~stall & ~bus.ex_flush;
  end

  always_comb begin
    cause = NONE;
    if (raw_a) begin
      cause = RAW_A;
    end else if (raw_b) begin
      cause = RAW_B;
    end else if (waw) begin
      cause = WAW;
    end
  end

  always_comb begin
    stat_d = stat_q;
    if (stall && (stat_q != '1)) begin
      stat_d = stat_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.pc_write     = ~stall;
  assign bus.ifid_write   = ~stall;
  assign bus.idex_bubble  = stall | bus.ex_flush;
  assign bus.busy_mask    = busy;
  assign bus.stall_cycles = stat_q;

  a_stall_has_cause: assert property (@(posedge clk) disable iff (!rst_n) stall |-> (cause != NONE));

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
// tb/tb_scoreboard_stall_unit.sv - self-checking bench with time-based ready model for scoreboard_stall_unit
module tb_scoreboard_stall_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   hold;

  always #5 clk = ~clk;

  scoreboard_stall_unit_if #(.STAT_W(16)) hz ();
  scoreboard_stall_unit_if #(.STAT_W(4))  hz_s ();

  assign hz_s.id_valid     = hz.id_valid;
  assign hz_s.id_rs        = hz.id_rs;
  assign hz_s.id_rt        = hz.id_rt;
  assign hz_s.id_uses_rs   = hz.id_uses_rs;
  assign hz_s.id_uses_rt   = hz.id_uses_rt;
  assign hz_s.id_rd        = hz.id_rd;
  assign hz_s.id_reg_write = hz.id_reg_write;
  assign hz_s.id_lat       = hz.id_lat;
  assign hz_s.ex_flush     = hz.ex_flush;

  scoreboard_stall_unit #(.STAT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(hz));
  scoreboard_stall_unit #(.STAT_W(4))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(hz_s));

  // Model: ready[r] is the first ID cycle in which a consumer of r may issue.
  int ready [16] = '{default: 0};
  int now   = 0;
  int total = 0;

  function automatic int rem(input int r);
    if (r == 0) return 0;
    return (ready[r] > now) ? ready[r] - now : 0;
  endfunction

  function automatic bit m_stall();
    bit hazard;
    hazard = (hz.id_uses_rs && rem(int'(hz.id_rs)) > 0) ||
             (hz.id_uses_rt && rem(int'(hz.id_rt)) > 0) ||
             (hz.id_reg_write && hz.id_rd != 0 && rem(int'(hz.id_rd)) > int'(hz.id_lat));
    return hz.id_valid && !hz.ex_flush && hazard;
  endfunction

  function automatic int m_mask();
    int m = 0;
    for (int r = 1; r < 16; r++) if (rem(r) > 0) m |= (1 << r);
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) ready[r] <= 0;
      total <= 0;
    end else begin
      if (hz.id_valid && !hz.ex_flush && !m_stall() && hz.id_reg_write &&
          hz.id_rd != 0 && hz.id_lat != 0)
        ready[hz.id_rd] <= now + int'(hz.id_lat) + 1;
      if (m_stall()) total <= total + 1;
      now <= now + 1;
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit s;
    s = m_stall();
    vectors++;
    cmp("stall",        int'(hz.stall),        int'(s));
    cmp("pc_write",     int'(hz.pc_write),     int'(!s));
    cmp("ifid_write",   int'(hz.ifid_write),   int'(!s));
    cmp("idex_bubble",  int'(hz.idex_bubble),  int'(s || hz.ex_flush));
    cmp("busy_mask",    int'(hz.busy_mask),    m_mask());
    cmp("stall_cycles", int'(hz.stall_cycles), (total > 65535) ? 65535 : total);
    cmp("sat_cycles",   int'(hz_s.stall_cycles), (total > 15) ? 15 : total);
    cmp("sat_busy",     int'(hz_s.busy_mask),  m_mask());
  end

  task automatic lit(input string nm, input int act, input int exp);
    vectors++;
    cmp(nm, act, exp);
  endtask

  task automatic drive(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input int rd, input bit rw, input int lat, input bit fl);
    hz.id_valid     = v;
    hz.id_rs        = 4'(rs);
    hz.id_uses_rs   = urs;
    hz.id_rt        = 4'(rt);
    hz.id_uses_rt   = urt;
    hz.id_rd        = 4'(rd);
    hz.id_reg_write = rw;
    hz.id_lat       = 3'(lat);
    hz.ex_flush     = fl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with garbage on the inputs
    drive(1, 3, 1, 5, 1, 7, 1, 5, 0);
    @(negedge clk);
    lit("rst_stall", int'(hz.stall), 0);
    lit("rst_pc_write", int'(hz.pc_write), 1);
    lit("rst_busy", int'(hz.busy_mask), 0);
    lit("rst_cycles", int'(hz.stall_cycles), 0);
    tick();
    rst_n = 1'b1;

    // Load r3 lat 2, then add r5,r3,r4
    drive(1, 0, 0, 0, 0, 3, 1, 2, 0);
    @(negedge clk); lit("load_nostall", int'(hz.stall), 0);
    tick();
    drive(1, 3, 1, 4, 1, 5, 1, 0, 0);
    @(negedge clk);
    lit("lu_busy", int'(hz.busy_mask), 16'h0008);
    lit("lu_stall1", int'(hz.stall), 1);
    lit("lu_bubble1", int'(hz.idex_bubble), 1);
    tick();
    @(negedge clk);
    lit("lu_stall2", int'(hz.stall), 1);
    lit("lu_bubble2", int'(hz.idex_bubble), 1);
    tick();
    @(negedge clk);
    lit("lu_issue", int'(hz.stall), 0);
    lit("lu_cycles", int'(hz.stall_cycles), 2);
    tick();

    // r0 is never tracked; unused rt never stalls
    drive(1, 0, 0, 0, 0, 0, 1, 3, 0);
    @(negedge clk); tick();
    drive(1, 0, 1, 4, 1, 9, 1, 0, 0);
    @(negedge clk);
    lit("r0_stall", int'(hz.stall), 0);
    lit("r0_busy", int'(hz.busy_mask), 0);
    tick();
    drive(1, 0, 0, 0, 0, 3, 1, 3, 0);
    @(negedge clk); tick();
    drive(1, 3, 0, 3, 0, 8, 0, 0, 0);
    @(negedge clk);
    lit("unused_src", int'(hz.stall), 0);
    tick();
    nop();
    repeat (4) begin @(negedge clk); tick(); end

    // WAW: r6 lat 3 followed by a lat-1 write to r6
    drive(1, 0, 0, 0, 0, 6, 1, 3, 0);
    @(negedge clk); tick();
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
    @(negedge clk); lit("waw_stall1", int'(hz.stall), 1); tick();
    @(negedge clk); lit("waw_stall2", int'(hz.stall), 1); tick();
    @(negedge clk); lit("waw_issue", int'(hz.stall), 0); tick();
    nop();
    @(negedge clk); lit("waw_reload", int'(hz.busy_mask), 16'h0040); tick();
    @(negedge clk); lit("waw_done", int'(hz.busy_mask), 0); tick();

    // Flush while stalled on r7
    drive(1, 0, 0, 0, 0, 7, 1, 3, 0);
    @(negedge clk); tick();
    drive(1, 7, 1, 0, 0, 9, 1, 5, 0);
    @(negedge clk); lit("fl_pre", int'(hz.stall), 1); tick();
    hz.ex_flush = 1'b1;
    @(negedge clk);
    lit("fl_stall", int'(hz.stall), 0);
    lit("fl_bubble", int'(hz.idex_bubble), 1);
    tick();
    nop();
    @(negedge clk); lit("fl_noupd", int'(hz.busy_mask), 16'h0080); tick();
    @(negedge clk); lit("fl_drain", int'(hz.busy_mask), 0); tick();

    // Asynchronous reset in the middle of a stall
    drive(1, 0, 0, 0, 0, 2, 1, 3, 0);
    @(negedge clk); tick();
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); lit("ar_pre", int'(hz.stall), 1); tick();
    #2 rst_n = 1'b0;
    #1;
    lit("ar_stall", int'(hz.stall), 0);
    lit("ar_busy", int'(hz.busy_mask), 0);
    lit("ar_pc_write", int'(hz.pc_write), 1);
    lit("ar_cycles", int'(hz.stall_cycles), 0);
    tick();
    rst_n = 1'b1;

    // 21 stall cycles: saturates the 4-bit counter at 15
    repeat (3) begin
      drive(1, 0, 0, 0, 0, 1, 1, 7, 0);
      @(negedge clk); tick();
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
      repeat (8) begin @(negedge clk); tick(); end
    end
    nop();
    @(negedge clk);
    lit("sat_max", int'(hz_s.stall_cycles), 15);
    lit("sat_wide", int'(hz.stall_cycles), 21);
    tick();

    // Randomized traffic; a stalled instruction usually stays in ID
    hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if (!hold)
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 9) == 0);
      @(negedge clk);
      hold = m_stall() && ($urandom_range(0, 3) != 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scoreboard_stall_unit.md
Name: scoreboard_stall_unit

Overview:
- Decode-stage hazard unit; the producer-side counterpart to the EX-stage forwarding logic.
- Tracks destination registers of in-flight multi-cycle producers (loads, multi-cycle ALU ops) in a per-register countdown scoreboard.
- Stalls PC and IF/ID and injects an ID/EX bubble when a decoding instruction needs a result that forwarding cannot yet supply.
- Sits between the decoder outputs and the pipeline-register enables.

Parameters:
- REG_ADDR_W, 4, register address width (16 architectural registers; r0 hardwired zero).
- LAT_W, 3, width of the latency field and of each scoreboard counter (max 7 bubble cycles).
- STAT_W, 16, width of the saturating stall-cycle statistics counter.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_ADDR_W  source register A.
- id_rt  in  REG_ADDR_W  source register B.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_rd  in  REG_ADDR_W  destination register.
- id_reg_write  in  1  instruction writes id_rd.
- id_lat  in  LAT_W  bubble cycles a consumer of this result needs (0 = fully forwardable ALU result).
- ex_flush  in  1  branch flush; the ID instruction is squashed this cycle.
- stall  out  1  hazard detected this cycle.
- pc_write  out  1  PC enable (= ~stall).
- ifid_write  out  1  IF/ID enable (= ~stall).
- idex_bubble  out  1  load NOP controls into ID/EX (stall | ex_flush).
- busy_mask  out  16  bit i set when cnt[i] != 0.
- stall_cycles  out  STAT_W  saturating count of stalled cycles.

Behaviour:
- State: cnt[1..15], LAT_W bits each. cnt[0] is constant 0 and is never written.
- Reset (async, rst_n=0): all cnt = 0 and stall_cycles = 0. This gives stall=0, pc_write=1, ifid_write=1, idex_bubble=0, busy_mask=0. Reset mid-stall releases the stall immediately.
- Hazard terms (combinational from registered cnt, zero latency):
  - raw_a = id_uses_rs & (cnt[id_rs] != 0)
  - raw_b = id_uses_rt & (cnt[id_rt] != 0)
  - waw = id_reg_write & (id_rd != 0) & (cnt[id_rd] > id_lat)
- stall = id_valid & ~ex_flush & (raw_a | raw_b | waw). ex_flush forces stall=0.
- issue = id_valid & ~stall & ~ex_flush.
- Per edge, for each i != 0:
  - if issue & id_reg_write & id_rd == i & id_lat != 0: cnt[i] <= id_lat. Issue wins over decrement on the same register.
  - else if cnt[i] != 0: cnt[i] <= cnt[i] - 1.
  - else hold.
- Stall length: a producer with id_lat = N issued at edge T blocks a dependent consumer for exactly N cycles. The consumer issues in cycle T+N+1 relative to the producer's ID cycle.
- Flush does not clear counters of already-issued producers. Squashed instructions never update the scoreboard.
- Registers addressed as 0 never cause a hazard and are never tracked.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones (no wrap).
- Unused sources (uses_* = 0) never stall, even if the address field matches a busy register.

Decomposition:
- Shared package pipe_hazard_pkg holds REG_ADDR_W, LAT_W, NUM_REGS=16, and the hazard-cause enum {NONE, RAW_A, RAW_B, WAW} used for debug and assertions.
- One sub-module, sb_counter: a single scoreboard slot with inputs load, load_val, and async reset; outputs count and busy. Instantiate 15 times via generate.

Test Plan:
- Reset: rst_n=0 with garbage inputs -> stall=0, pc_write=1, busy_mask=0, stall_cycles=0. Release, then issue a load r3 with id_lat=2 -> busy_mask=0x0008 next cycle.
- Load-use: load r3 (lat 2), then add r5,r3,r4 -> stall=1 for exactly 2 cycles, idex_bubble=1 both cycles, add issues on the third cycle, stall_cycles=2.
- Unused and zero registers: load r0 (lat 3), then add using rs=r0 -> no stall, busy_mask stays 0. Also, uses_rt=0 with id_rt=r3 busy -> no stall.
- WAW: load r6 (lat 3), next instruction writes r6 with id_lat=1 -> stalls until cnt[6]<=1 (2 cycles), then cnt[6] reloads to 1.
- Flush: r7 busy with stall active and ex_flush=1 -> stall=0, idex_bubble=1, no scoreboard update. cnt[7] keeps decrementing to 0.
- Async reset mid-stall: assert rst_n=0 between edges during a 3-cycle stall -> stall drops immediately, all cnt=0. Saturation check: preload stall_cycles near max, hold a hazard -> value stops at 0xFFFF.
